// File: rtl/matrix_addsub_alu_if.sv
// Bus between the execution engine (master) and the matrix add/sub unit (slave).
interface matrix_addsub_alu_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 256;

  logic [ADDR_W-1:0] address;
  logic              nRead;
  logic              nWrite;
  logic [DATA_W-1:0] ExeDataOut;
  logic [DATA_W-1:0] MatrixDataOut;
  logic              Busy;

  modport master (
    output address, nRead, nWrite, ExeDataOut,
    input  MatrixDataOut, Busy
  );

  modport slave (
    input  address, nRead, nWrite, ExeDataOut,
    output MatrixDataOut, Busy
  );
endinterface

// File: rtl/matrix_addsub_alu.sv
// Memory-mapped 4x4 element-wise matrix add/subtract unit with a multi-cycle COMPUTE phase.
// Optional feature: define MATRIX_SAT_EN for signed saturation and a sticky overflow flag.
module matrix_addsub_alu #(
  parameter logic [15:0] BASE_ADDR      = 16'h2010,
  parameter int unsigned ELEM_W         = 16,
  parameter int unsigned DIM            = 4,
  parameter int unsigned ROWS_PER_CYCLE = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  matrix_addsub_alu_if.slave  bus
);

  localparam int unsigned DATA_W   = DIM * DIM * ELEM_W;
  localparam int unsigned ROW_W    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned LAST_ROW = DIM - ROWS_PER_CYCLE;

  localparam logic [2:0] OFF_SRC1    = 3'd0;
  localparam logic [2:0] OFF_SRC2    = 3'd1;
  localparam logic [2:0] OFF_RESULT  = 3'd2;
  localparam logic [2:0] OFF_CMD_ADD = 3'd3;
  localparam logic [2:0] OFF_CMD_SUB = 3'd4;
  localparam logic [2:0] OFF_STATUS  = 3'd5;

`ifdef MATRIX_SAT_EN
  localparam logic [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              state_q, state_nxt;
  logic [ROW_W-1:0]    row_q, row_nxt;
  logic                sub_q, sub_nxt;
  logic [DATA_W-1:0]   src1_q, src1_nxt;
  logic [DATA_W-1:0]   src2_q, src2_nxt;
  logic [DATA_W-1:0]   result_q, result_nxt;
  logic [DATA_W-1:0]   dout_q, dout_nxt;
  logic                follow_q, follow_nxt;
  logic                busy_q;
  logic                prev_add_q, prev_sub_q;
`ifdef MATRIX_SAT_EN
  logic                ovf_q, ovf_nxt;
`endif

  // Window decode: BASE_ADDR..BASE_ADDR+7
  logic [15:0] offs;
  logic        in_win;
  logic        wr_src1, wr_src2, wr_add, wr_sub, rd_res, rd_stat;
  logic        start_add, start_sub;

  assign offs    = bus.address - BASE_ADDR;
  assign in_win  = (offs[15:3] == 13'd0);
  assign wr_src1 = !bus.nWrite && in_win && (offs[2:0] == OFF_SRC1);
  assign wr_src2 = !bus.nWrite && in_win && (offs[2:0] == OFF_SRC2);
  assign wr_add  = !bus.nWrite && in_win && (offs[2:0] == OFF_CMD_ADD);
  assign wr_sub  = !bus.nWrite && in_win && (offs[2:0] == OFF_CMD_SUB);
  assign rd_res  = !bus.nRead  && in_win && (offs[2:0] == OFF_RESULT);
  assign rd_stat = !bus.nRead  && in_win && (offs[2:0] == OFF_STATUS);

  // Commands fire only on the first cycle of a held strobe
  assign start_add = wr_add && !prev_add_q;
  assign start_sub = wr_sub && !prev_sub_q;

  // Next-state, datapath and read-port logic
  always_comb begin
    logic [DATA_W-1:0] status_w;
    logic [ELEM_W-1:0] a_e, b_e, r_e;
    int unsigned       idx;
`ifdef MATRIX_SAT_EN
    logic signed [ELEM_W:0] a_x, b_x, s_x;
`endif

    state_nxt  = state_q;
    row_nxt    = row_q;
    sub_nxt    = sub_q;
    src1_nxt   = src1_q;
    src2_nxt   = src2_q;
    result_nxt = result_q;
    dout_nxt   = dout_q;
    follow_nxt = 1'b0;
    status_w   = '0;
    a_e        = '0;
    b_e        = '0;
    r_e        = '0;
    idx        = 0;
`ifdef MATRIX_SAT_EN
    ovf_nxt    = ovf_q;
    a_x        = '0;
    b_x        = '0;
    s_x        = '0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (wr_src1) src1_nxt = bus.ExeDataOut;
        if (wr_src2) src2_nxt = bus.ExeDataOut;
        if (start_add || start_sub) begin
          state_nxt = S_COMPUTE;
          row_nxt   = '0;
          sub_nxt   = start_sub;
`ifdef MATRIX_SAT_EN
          ovf_nxt   = 1'b0;
`endif
        end
      end
      S_COMPUTE: begin
        for (int g = 0; g < int'(ROWS_PER_CYCLE); g++) begin
          for (int c = 0; c < int'(DIM); c++) begin
            idx = (int'(row_q) + g) * DIM + c;
            a_e = src1_q[idx*ELEM_W +: ELEM_W];
            b_e = src2_q[idx*ELEM_W +: ELEM_W];
`ifdef MATRIX_SAT_EN
            a_x = {a_e[ELEM_W-1], a_e};
            b_x = {b_e[ELEM_W-1], b_e};
            s_x = sub_q ? (a_x - b_x) : (a_x + b_x);
            if (s_x[ELEM_W] != s_x[ELEM_W-1]) begin
              r_e     = s_x[ELEM_W] ? SAT_MIN : SAT_MAX;
              ovf_nxt = 1'b1;
            end else begin
              r_e = s_x[ELEM_W-1:0];
            end
`else
            r_e = sub_q ? (a_e - b_e) : (a_e + b_e);
`endif
            result_nxt[idx*ELEM_W +: ELEM_W] = r_e;
          end
        end
        if (row_q == ROW_W'(LAST_ROW)) begin
          state_nxt = S_DONE;
          row_nxt   = '0;
        end else begin
          row_nxt = row_q + ROW_W'(ROWS_PER_CYCLE);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    status_w[0] = (state_q == S_COMPUTE);
    status_w[1] = (state_q == S_DONE);
`ifdef MATRIX_SAT_EN
    status_w[2] = ovf_q;
`endif

    // A RESULT read during COMPUTE keeps tracking the register until the op lands
    if (rd_res) begin
      dout_nxt = result_nxt;
    end else if (rd_stat) begin
      dout_nxt = status_w;
    end else if (follow_q && (state_q == S_COMPUTE)) begin
      dout_nxt = result_nxt;
    end
    follow_nxt = (state_q == S_COMPUTE) && (rd_res || (follow_q && !rd_stat));
  end

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      sub_q      <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      result_q   <= '0;
      dout_q     <= '0;
      follow_q   <= 1'b0;
      busy_q     <= 1'b0;
      prev_add_q <= 1'b0;
      prev_sub_q <= 1'b0;
`ifdef MATRIX_SAT_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      row_q      <= row_nxt;
      sub_q      <= sub_nxt;
      src1_q     <= src1_nxt;
      src2_q     <= src2_nxt;
      result_q   <= result_nxt;
      dout_q     <= dout_nxt;
      follow_q   <= follow_nxt;
      busy_q     <= (state_nxt == S_COMPUTE);
      prev_add_q <= wr_add;
      prev_sub_q <= wr_sub;
`ifdef MATRIX_SAT_EN
      ovf_q      <= ovf_nxt;
`endif
    end
  end

  assign bus.MatrixDataOut = dout_q;
  assign bus.Busy          = busy_q;

endmodule

// File: tb/tb_matrix_addsub_alu.sv
// Scoreboard bench for matrix_addsub_alu: reads push expectations, a monitor checks 2 cycles later.
module tb_matrix_addsub_alu;

  localparam logic [15:0] BASE = 16'h2010;
  localparam logic [2:0]  O_SRC1 = 3'd0, O_SRC2 = 3'd1, O_RES = 3'd2;
  localparam logic [2:0]  O_ADD  = 3'd3, O_SUB  = 3'd4, O_STAT = 3'd5;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  matrix_addsub_alu_if bus ();

  matrix_addsub_alu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int rd_id = 0;
  logic [255:0] exp_q[$];
  int           id_q[$];

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] m;
    for (int e = 0; e < 16; e++) m[e*16 +: 16] = v;
    return m;
  endfunction

  // Element (r,c) = r*4+c+off
  function automatic logic [255:0] ramp(input logic [15:0] off);
    logic [255:0] m;
    for (int e = 0; e < 16; e++) m[e*16 +: 16] = 16'(e) + off;
    return m;
  endfunction

  task automatic idle();
    bus.address    = 16'h0000;
    bus.nRead      = 1'b1;
    bus.nWrite     = 1'b1;
    bus.ExeDataOut = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_wr(input logic [2:0] off, input logic [255:0] d);
    bus.address    = BASE + 16'(off);
    bus.nWrite     = 1'b0;
    bus.nRead      = 1'b1;
    bus.ExeDataOut = d;
  endtask

  task automatic wr(input logic [2:0] off, input logic [255:0] d);
    drive_wr(off, d);
    tick();
    idle();
  endtask

  // One-cycle read strobe followed by one quiet cycle
  task automatic rd(input logic [2:0] off, input logic [255:0] e);
    bus.address = BASE + 16'(off);
    bus.nRead   = 1'b0;
    bus.nWrite  = 1'b1;
    exp_q.push_back(e);
    id_q.push_back(rd_id);
    rd_id++;
    tick();
    idle();
    tick();
  endtask

  task automatic check_busy(input string nm, input logic e);
    total++;
    if (bus.Busy !== e) begin
      bad++;
      $display("FAIL %s busy=%b expected=%b", nm, bus.Busy, e);
    end
  endtask

  task automatic check_dout(input string nm, input logic [255:0] e);
    total++;
    if (bus.MatrixDataOut !== e) begin
      bad++;
      $display("FAIL %s data=%h expected=%h", nm, bus.MatrixDataOut, e);
    end
  endtask

  // Monitor: compare MatrixDataOut two cycles after each RESULT/STATUS read strobe
  initial begin : monitor
    logic s1, s2, cur;
    logic [255:0] e;
    int id;
    s1 = 1'b0;
    s2 = 1'b0;
    forever begin
      @(negedge Clk);
      cur = !bus.nRead && ((bus.address == BASE + 16'(O_RES)) ||
                           (bus.address == BASE + 16'(O_STAT)));
      if (s2) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL read_unexpected data=%h", bus.MatrixDataOut);
        end else begin
          e  = exp_q.pop_front();
          id = id_q.pop_front();
          if (bus.MatrixDataOut !== e) begin
            bad++;
            $display("FAIL read#%0d data=%h expected=%h", id, bus.MatrixDataOut, e);
          end
        end
      end
      s2 = s1;
      s1 = cur;
    end
  end

  logic [255:0] exp_ovf_res, exp_neg_res, exp_ovf_stat;

  initial begin : stim
    int guard;
`ifdef MATRIX_SAT_EN
    exp_ovf_res  = fill(16'h7FFF);
    exp_neg_res  = fill(16'h8000);
    exp_ovf_stat = 256'd6;
`else
    exp_ovf_res  = fill(16'h8000);
    exp_neg_res  = fill(16'h7FFF);
    exp_ovf_stat = 256'd2;
`endif
    idle();
    Reset = 1'b1;
    wait_cyc(3);
    Reset = 1'b0;
    tick();

    // Reset state
    check_busy("reset_busy", 1'b0);
    check_dout("reset_dout", '0);
    rd(O_STAT, 256'd0);
    rd(O_RES, 256'd0);

    // Add with CMD_ADD held 4 cycles: exactly one operation
    wr(O_SRC1, fill(16'd3));
    wr(O_SRC2, fill(16'd5));
    drive_wr(O_ADD, '0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) idle();
      check_busy($sformatf("add_busy_t%0d", k), (k <= 2));
    end
    rd(O_STAT, 256'd2);
    rd(O_RES, fill(16'd8));

    // Subtract: ramp - 1
    wr(O_SRC1, ramp(16'd0));
    wr(O_SRC2, fill(16'd1));
    wr(O_SUB, '0);
    check_busy("sub_busy", 1'b1);
    wait_cyc(3);
    rd(O_RES, ramp(16'hFFFF));
    rd(O_STAT, 256'd2);

    // Overflow boundaries
    wr(O_SRC1, fill(16'h7FFF));
    wr(O_SRC2, fill(16'h0001));
    wr(O_ADD, '0);
    wait_cyc(3);
    rd(O_RES, exp_ovf_res);
    rd(O_STAT, exp_ovf_stat);
    wr(O_SRC1, fill(16'h8000));
    wr(O_SUB, '0);
    wait_cyc(3);
    rd(O_RES, exp_neg_res);
    rd(O_STAT, exp_ovf_stat);

    // Engine sequence: RESULT read the cycle after the command
    wr(O_SRC1, fill(16'd10));
    wr(O_SRC2, fill(16'd20));
    drive_wr(O_ADD, '0);
    tick();
    rd(O_RES, fill(16'd30));
    rd(O_STAT, 256'd2);

    // Busy guard: CMD_SUB and SRC1 write during COMPUTE are dropped
    wr(O_SRC1, fill(16'd100));
    wr(O_SRC2, fill(16'd1));
    wr(O_ADD, '0);
    wr(O_SUB, '0);
    wr(O_SRC1, fill(16'd500));
    check_busy("guard_busy_after", 1'b0);
    wait_cyc(2);
    rd(O_RES, fill(16'd101));
    rd(O_STAT, 256'd2);
    wr(O_SUB, '0);
    wait_cyc(3);
    rd(O_RES, fill(16'd99));

    // Reset in the middle of COMPUTE
    wr(O_SRC1, fill(16'd7));
    wr(O_ADD, '0);
    check_busy("midreset_busy_pre", 1'b1);
    Reset = 1'b1;
    wait_cyc(2);
    Reset = 1'b0;
    check_busy("midreset_busy", 1'b0);
    check_dout("midreset_dout", '0);
    tick();
    check_busy("midreset_busy_post", 1'b0);
    rd(O_STAT, 256'd0);
    rd(O_RES, 256'd0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
